// File: rtl/fp_div_seq.sv
// Sequential IEEE754-format divider: one restoring quotient bit per cycle,
// truncating rounding, saturating overflow and flush-to-zero underflow.
module fp_div_seq #(
  parameter int N = 32,
  parameter int M = 23
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] OUT,
  output logic         OverFlow,
  output logic         UnderFlow,
  output logic         DivByZero,
  output logic         busy
);

  localparam int EW   = N - M - 1;
  localparam int CW   = $clog2(M + 2);
  localparam int XW   = EW + 2;
  localparam int BIAS = (1 << (EW - 1)) - 1;

  localparam logic [EW-1:0]        EMAX    = '1;
  localparam logic signed [XW-1:0] BIAS_HI = XW'(BIAS);
  localparam logic signed [XW-1:0] BIAS_LO = XW'(BIAS - 1);
  localparam logic signed [XW-1:0] EMAX_E  = XW'((1 << EW) - 1);
  localparam logic signed [XW-1:0] ZERO_E  = '0;

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [M+1:0]            rem;
  logic [M+1:0]            q;
  logic [M:0]              divisor;
  logic [EW-1:0]           ea;
  logic [EW-1:0]           eb;
  logic                    sign;

  logic                    accept;
  logic [EW-1:0]           a_exp;
  logic [EW-1:0]           b_exp;
  logic [M+1:0]            div_ext;
  logic                    q_bit;
  logic [M+1:0]            rem_nxt;
  logic signed [XW-1:0]    exp_n;
  logic [M-1:0]            mant_n;

  // Packs the result word and saturates the exponent; returns {of, uf, word}.
  function automatic logic [N+1:0] pack_sat(input logic s,
                                            input logic signed [XW-1:0] e,
                                            input logic [M-1:0] mant);
    if (e >= EMAX_E)
      return {1'b1, 1'b0, s, {(N-1){1'b1}}};
    else if (e <= ZERO_E)
      return {1'b0, 1'b1, s, {(N-1){1'b0}}};
    else
      return {2'b00, s, e[EW-1:0], mant};
  endfunction

  assign accept  = in_valid && in_ready;
  assign a_exp   = A[N-2:M];
  assign b_exp   = B[N-2:M];
  assign div_ext = {1'b0, divisor};
  assign q_bit   = (rem >= div_ext);
  assign rem_nxt = (q_bit ? (rem - div_ext) : rem) << 1;
  assign exp_n   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + (q[M+1] ? BIAS_HI : BIAS_LO);
  assign mant_n  = q[M+1] ? q[M:1] : q[M-1:0];

  // Operand fields needed after acceptance; only meaningful while an op is live.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      sign    <= A[N-1] ^ B[N-1];
      ea      <= a_exp;
      eb      <= b_exp;
      divisor <= {1'b1, B[M-1:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      q         <= '0;
      OUT       <= '0;
      OverFlow  <= 1'b0;
      UnderFlow <= 1'b0;
      DivByZero <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (b_exp == '0) begin
              OUT       <= {A[N-1] ^ B[N-1], EMAX, {M{1'b0}}};
              OverFlow  <= 1'b0;
              UnderFlow <= 1'b0;
              DivByZero <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (a_exp == '0) begin
              OUT       <= {A[N-1] ^ B[N-1], {(N-1){1'b0}}};
              OverFlow  <= 1'b0;
              UnderFlow <= 1'b0;
              DivByZero <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              rem   <= {2'b01, A[M-1:0]};
              q     <= '0;
              cnt   <= CW'(M + 1);
              state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          rem <= rem_nxt;
          q   <= {q[M:0], q_bit};
          if (cnt == '0)
            state <= NORM;
          else
            cnt <= cnt - 1'b1;
        end
        NORM: begin
          {OverFlow, UnderFlow, OUT} <= pack_sat(sign, exp_n, mant_n);
          DivByZero <= 1'b0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: hand-computed quotients, special cases,
// latency, backpressure and mid-operation reset.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] OUT;
  logic        OverFlow;
  logic        UnderFlow;
  logic        DivByZero;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  fp_div_seq #(.N(32), .M(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .OUT       (OUT),
    .OverFlow  (OverFlow),
    .UnderFlow (UnderFlow),
    .DivByZero (DivByZero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // flags are {OverFlow, UnderFlow, DivByZero}
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_out, input logic [2:0] exp_flags,
                        input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    check({name, " in_ready idle"}, in_ready, 1);
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " OUT"}, OUT, exp_out);
    check({name, " flags"}, {OverFlow, UnderFlow, DivByZero}, exp_flags);
    check({name, " busy"}, busy, 1);
    @(negedge clk);
    in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({name, " hold valid"}, out_valid, 1);
      check({name, " hold OUT"}, OUT, exp_out);
      check({name, " hold flags"}, {OverFlow, UnderFlow, DivByZero}, exp_flags);
      check({name, " hold in_ready"}, in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check({name, " consumed valid"}, out_valid, 0);
    check({name, " consumed in_ready"}, in_ready, 1);
    check({name, " no accept on consume"}, busy, 0);
    check({name, " OUT retained"}, OUT, exp_out);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", in_ready, 0);
    check("reset busy", busy, 0);
    check("reset out_valid", out_valid, 0);
    check("reset OUT", OUT, 0);
    check("reset flags", {OverFlow, UnderFlow, DivByZero}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready after reset", in_ready, 1);

    run_op("6/2",       32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 26, 10);
    run_op("1/1.5",     32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, 3'b000, 26, 0);
    run_op("ovf",       32'h7F000000, 32'h00800000, 32'h7FFFFFFF, 3'b100, 26, 2);
    run_op("unf",       32'h00800000, 32'h7F000000, 32'h00000000, 3'b010, 26, 0);
    run_op("div0",      32'hBF800000, 32'h00000000, 32'hFF800000, 3'b001, 0, 3);
    run_op("zero/1",    32'h00000000, 32'h3F800000, 32'h00000000, 3'b000, 0, 0);
    run_op("-6/2",      32'hC0C00000, 32'h40000000, 32'hC0400000, 3'b000, 26, 0);
    run_op("e255/2",    32'h7F800000, 32'h40000000, 32'h7F000000, 3'b000, 26, 0);
    run_op("e255 ovf",  32'h7F800000, 32'h3F800000, 32'h7FFFFFFF, 3'b100, 26, 0);
    run_op("e254",      32'h7F000000, 32'h3F800000, 32'h7F000000, 3'b000, 26, 0);
    run_op("e0 unf",    32'h00800000, 32'h3FC00000, 32'h00000000, 3'b010, 26, 0);
    run_op("e1",        32'h00800000, 32'h3F800000, 32'h00800000, 3'b000, 26, 0);
    run_op("0/0",       32'h00000000, 32'h80000000, 32'hFF800000, 3'b001, 0, 0);
    run_op("denA",      32'h80400000, 32'h3F800000, 32'h80000000, 3'b000, 0, 0);
    run_op("1/3",       32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000, 26, 0);
    run_op("-2/-3",     32'hC0000000, 32'hC0400000, 32'h3F2AAAAA, 3'b000, 26, 1);

    // Reset in the middle of DIVIDE
    @(negedge clk);
    A = 32'h40C00000;
    B = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst OUT", OUT, 0);
    check("midrst flags", {OverFlow, UnderFlow, DivByZero}, 0);
    check("midrst out_valid", out_valid, 0);
    check("midrst busy", busy, 0);
    check("midrst in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("midrst no out_valid", seen, 0);
    run_op("after rst", 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 26, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
